// File: rtl/alu_uart_pkg.sv
// ---------------------------------------------------------------------------
// alu_uart_pkg
// Shared definitions for the ALU command path. Used by alu_cmd_master and by
// the UART-side interface block so both agree on state encoding, data widths
// and opcode values.
//   - cmd_state_e   : command FSM state encoding
//   - BUS_SIZE_DEF  : default data byte width
//   - OP_SIZE_DEF   : default opcode width
//   - OP_*          : ALU opcode constants (MIPS-style funct codes)
//   - op_is_shift   : helper used by the UART side to classify opcodes
// ---------------------------------------------------------------------------
package alu_uart_pkg;

  localparam int BUS_SIZE_DEF = 8;
  localparam int OP_SIZE_DEF  = 6;

  // Command FSM: one operand byte per SEND state, then wait for the result.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    SEND_OP  = 3'd3,
    WAIT_RES = 3'd4
  } cmd_state_e;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  // True for the two shift opcodes (operand B is a shift amount there).
  function automatic logic op_is_shift(input logic [5:0] op);
    logic result;
    case (op)
      OP_SRA:  result = 1'b1;
      OP_SRL:  result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/alu_cmd_timer.sv
// ---------------------------------------------------------------------------
// alu_cmd_timer
// Wait-for-result watchdog counter for alu_cmd_master. Counts enabled cycles
// after a clear and flags the last allowed cycle.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_clear     : synchronous clear of the count (has priority)
//   i_enable    : count this cycle
//   o_expired   : high on the CYCLES-th enabled cycle since the last clear
// ---------------------------------------------------------------------------
module alu_cmd_timer #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int          CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // Cycle counter; saturates at LAST so a stalled consumer cannot wrap it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  // The count starts at 0 on the first enabled cycle, so LAST marks cycle CYCLES.
  assign o_expired = i_enable & (r_count == LAST);

endmodule

// File: rtl/alu_cmd_master.sv
// ---------------------------------------------------------------------------
// alu_cmd_master
// Issues one ALU command as three bytes (A, B, opcode) into a TX FIFO, then
// waits for the single result byte from an RX FIFO (first-word-fall-through).
// Stray RX bytes seen while idle are drained without affecting the result.
//
// Optional feature: define ALU_CMD_TIMEOUT_EN to bound the result wait to
// TIMEOUT_CYCLES cycles (o_timeout pulse). Without it the wait is unbounded
// and o_timeout is tied low.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   i_start             : issue a command (sampled only in IDLE)
//   i_op_a/i_op_b       : operands, latched on accept
//   i_op_code           : opcode, latched on accept, zero-extended when sent
//   tx_full/o_wr/o_wdata: TX FIFO push side
//   rx_empty/i_rdata/o_rd: RX FIFO pop side
//   o_busy              : command in progress
//   o_result            : last received result
//   o_done/o_timeout    : one-cycle completion / expiry pulses
// OP_SIZE must not exceed BUS_SIZE.
// ---------------------------------------------------------------------------
module alu_cmd_master
  import alu_uart_pkg::*;
#(
  parameter int BUS_SIZE       = BUS_SIZE_DEF,
  parameter int OP_SIZE        = OP_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [BUS_SIZE-1:0] i_op_a,
  input  logic [BUS_SIZE-1:0] i_op_b,
  input  logic [OP_SIZE-1:0]  i_op_code,
  input  logic                tx_full,
  output logic                o_wr,
  output logic [BUS_SIZE-1:0] o_wdata,
  input  logic                rx_empty,
  input  logic [BUS_SIZE-1:0] i_rdata,
  output logic                o_rd,
  output logic                o_busy,
  output logic [BUS_SIZE-1:0] o_result,
  output logic                o_done,
  output logic                o_timeout
);

  cmd_state_e          r_state;
  cmd_state_e          w_next_state;

  logic [BUS_SIZE-1:0] r_op_a;
  logic [BUS_SIZE-1:0] r_op_b;
  logic [OP_SIZE-1:0]  r_op_code;
  logic [BUS_SIZE-1:0] r_result;
  logic                r_done;
  logic                r_timeout;

  logic [BUS_SIZE-1:0] w_op_ext;
  logic                w_wr;
  logic [BUS_SIZE-1:0] w_wdata;
  logic                w_rd;
  logic                w_latch;
  logic                w_capture;
  logic                w_timeout_next;
  logic                w_expired;

  // Opcode widened to the bus width with zero upper bits.
  always_comb begin
    w_op_ext                = '0;
    w_op_ext[OP_SIZE-1:0]   = r_op_code;
  end

`ifdef ALU_CMD_TIMEOUT_EN
  logic w_in_wait;
  assign w_in_wait = (r_state == WAIT_RES);

  // Counter runs only while waiting and restarts from zero on every entry.
  alu_cmd_timer #(
    .CYCLES    (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (~w_in_wait),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Next-state and FIFO strobe decode.
  always_comb begin
    w_next_state   = r_state;
    w_wr           = 1'b0;
    w_wdata        = '0;
    w_rd           = 1'b0;
    w_latch        = 1'b0;
    w_capture      = 1'b0;
    w_timeout_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_latch      = 1'b1;
          w_next_state = SEND_A;
        end else if (!rx_empty) begin
          // Drain bytes that arrive with no command outstanding.
          w_rd = 1'b1;
        end else begin
          w_rd = 1'b0;
        end
      end
      SEND_A: begin
        w_wdata = r_op_a;
        w_wr    = ~tx_full;
        if (w_wr) begin
          w_next_state = SEND_B;
        end else begin
          w_next_state = SEND_A;
        end
      end
      SEND_B: begin
        w_wdata = r_op_b;
        w_wr    = ~tx_full;
        if (w_wr) begin
          w_next_state = SEND_OP;
        end else begin
          w_next_state = SEND_B;
        end
      end
      SEND_OP: begin
        w_wdata = w_op_ext;
        w_wr    = ~tx_full;
        if (w_wr) begin
          w_next_state = WAIT_RES;
        end else begin
          w_next_state = SEND_OP;
        end
      end
      WAIT_RES: begin
        // Data present on the expiry cycle takes precedence over the timeout.
        if (!rx_empty) begin
          w_rd         = 1'b1;
          w_capture    = 1'b1;
          w_next_state = IDLE;
        end else if (w_expired) begin
          w_timeout_next = 1'b1;
          w_next_state   = IDLE;
        end else begin
          w_next_state = WAIT_RES;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand latch, loaded only when a command is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_code <= '0;
    end else if (w_latch) begin
      r_op_a    <= i_op_a;
      r_op_b    <= i_op_b;
      r_op_code <= i_op_code;
    end else begin
      r_op_a    <= r_op_a;
      r_op_b    <= r_op_b;
      r_op_code <= r_op_code;
    end
  end

  // Result capture and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= w_capture;
      r_timeout <= w_timeout_next;
      if (w_capture) begin
        r_result <= i_rdata;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign o_wr      = w_wr;
  assign o_wdata   = w_wdata;
  // The drain path is combinational from rx_empty, so hold it off during reset.
  assign o_rd      = w_rd & ~reset;
  assign o_busy    = (r_state != IDLE);
  assign o_result  = r_result;
  assign o_done    = r_done;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_alu_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_master
// Self-checking bench for alu_cmd_master. The bench plays both FIFOs and the
// remote ALU: pushed bytes are collected, and once three bytes of a command
// have arrived the ALU model answers with the computed result after a chosen
// delay. Directed scenarios are followed by randomized commands.
// ---------------------------------------------------------------------------
module tb_alu_cmd_master;

  localparam int BW = 8;
  localparam int OW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [BW-1:0] i_op_a;
  logic [BW-1:0] i_op_b;
  logic [OW-1:0] i_op_code;
  logic          tx_full;
  logic          o_wr;
  logic [BW-1:0] o_wdata;
  logic          rx_empty;
  logic [BW-1:0] i_rdata;
  logic          o_rd;
  logic          o_busy;
  logic [BW-1:0] o_result;
  logic          o_done;
  logic          o_timeout;

  always #5 clk = ~clk;

  alu_cmd_master #(
    .BUS_SIZE       (BW),
    .OP_SIZE        (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .i_op_code (i_op_code),
    .tx_full   (tx_full),
    .o_wr      (o_wr),
    .o_wdata   (o_wdata),
    .rx_empty  (rx_empty),
    .i_rdata   (i_rdata),
    .o_rd      (o_rd),
    .o_busy    (o_busy),
    .o_result  (o_result),
    .o_done    (o_done),
    .o_timeout (o_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: what the far end computes for a command.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h03:   r = 8'($signed(a) >>> b);
      6'h02:   r = a >> b;
      6'h27:   r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

  // Environment state
  logic [7:0] rx_q[$];
  logic [7:0] push_q[$];
  int         push_it[$];
  int         rd_it[$];
  int         done_it[$];
  int         to_it[$];
  logic [7:0] res_at_done[$];
  int         it = 0;
  int         cmd_base = 0;
  int         stall_rem = 0;
  int         full_pct = 0;
  bit         stall_on_first = 1'b0;
  int         stall_len = 0;
  bit         resp_en = 1'b1;
  int         resp_delay = 0;
  int         resp_cnt = -1;
  logic [7:0] resp_val = 8'h00;

  // One clock cycle: drive FIFO status, observe mid-cycle, apply pops/replies.
  task automatic tick();
    bit rd_now;
    if (stall_rem > 0) begin
      tx_full = 1'b1;
      stall_rem--;
    end else begin
      tx_full = ($urandom_range(99) < full_pct);
    end
    rx_empty = (rx_q.size() == 0);
    i_rdata  = rx_empty ? 8'h00 : rx_q[0];
    @(negedge clk);
    check_eq("fifo_protocol", {29'd0, o_wr & tx_full, o_rd & rx_empty, o_done & o_timeout}, 32'd0);
    rd_now = o_rd;
    if (o_wr) begin
      push_q.push_back(o_wdata);
      push_it.push_back(it);
      if (stall_on_first && (push_q.size() == cmd_base + 1)) stall_rem = stall_len;
      if (resp_en && (push_q.size() > cmd_base) && (((push_q.size() - cmd_base) % 3) == 0)) begin
        resp_cnt = resp_delay;
        resp_val = alu_ref(push_q[$-2], push_q[$-1], push_q[$][5:0]);
      end
    end
    if (o_rd) rd_it.push_back(it);
    if (o_done) begin
      done_it.push_back(it);
      res_at_done.push_back(o_result);
    end
    if (o_timeout) to_it.push_back(it);
    @(posedge clk);
    #1;
    if (rd_now && (rx_q.size() > 0)) void'(rx_q.pop_front());
    if (resp_cnt == 0) rx_q.push_back(resp_val);
    if (resp_cnt >= 0) resp_cnt--;
    it++;
  endtask

  // Presents a command for one cycle, then scrambles the operand inputs.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    cmd_base  = push_q.size();
    it        = 0;
    i_op_a    = a;
    i_op_b    = b;
    i_op_code = op;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
    i_op_a    = 8'($urandom);
    i_op_b    = 8'($urandom);
    i_op_code = 6'($urandom);
  endtask

  // Full command with end-to-end checks on bytes pushed and result returned.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, output int done_at);
    int d0;
    int t0;
    int guard;
    d0    = done_it.size();
    t0    = to_it.size();
    guard = 0;
    issue(a, b, op);
    while ((done_it.size() == d0) && (to_it.size() == t0) && (guard < 300)) begin
      tick();
      guard++;
    end
    check_eq("cmd_finished", {31'd0, guard < 300}, 32'd1);
    check_eq("push_count", push_q.size() - cmd_base, 32'd3);
    if (push_q.size() - cmd_base >= 3) begin
      check_eq("push_a", push_q[cmd_base], a);
      check_eq("push_b", push_q[cmd_base+1], b);
      check_eq("push_op", push_q[cmd_base+2], {2'b00, op});
    end
    check_eq("done_count", done_it.size() - d0, 32'd1);
    check_eq("timeout_count", to_it.size() - t0, 32'd0);
    done_at = (done_it.size() > d0) ? done_it[$] : -1;
    if (done_it.size() > d0) check_eq("result", res_at_done[$], alu_ref(a, b, op));
    tick();
    check_eq("done_single_pulse", done_it.size() - d0, 32'd1);
    check_eq("idle_after_cmd", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn;
    int d0;
    int guard;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [5:0] rop;

    reset     = 1'b1;
    i_start   = 1'b0;
    i_op_a    = 8'h00;
    i_op_b    = 8'h00;
    i_op_code = 6'h00;
    tx_full   = 1'b0;
    rx_empty  = 1'b0;
    i_rdata   = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    // Reset values, with RX reporting data to show o_rd is held off.
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_wr", {31'd0, o_wr}, 32'd0);
    check_eq("rst_rd", {31'd0, o_rd}, 32'd0);
    check_eq("rst_done", {31'd0, o_done}, 32'd0);
    check_eq("rst_timeout", {31'd0, o_timeout}, 32'd0);
    check_eq("rst_result", o_result, 32'd0);
    rx_empty = 1'b1;
    reset    = 1'b0;
    tick();

    // Stray byte while idle is drained and ignored.
    rx_q.push_back(8'hAA);
    it = 0;
    repeat (4) tick();
    check_eq("stray_drained", rx_q.size(), 32'd0);
    check_eq("stray_pops", rd_it.size(), 32'd1);
    check_eq("stray_result", o_result, 32'd0);
    check_eq("stray_no_done", done_it.size(), 32'd0);

    // Minimum-latency command.
    full_pct = 0;
    resp_delay = 0;
    run_cmd(8'h05, 8'h03, 6'h20, dn);
    check_eq("lat_push1", push_it[cmd_base], 32'd1);
    check_eq("lat_push2", push_it[cmd_base+1], 32'd2);
    check_eq("lat_push3", push_it[cmd_base+2], 32'd3);
    check_eq("lat_rd", rd_it[$], 32'd4);
    check_eq("lat_done", dn, 32'd5);
    check_eq("lat_result", o_result, 32'h08);

    // TX full for five cycles while sending B.
    stall_on_first = 1'b1;
    stall_len = 5;
    run_cmd(8'h3C, 8'hC3, 6'h26, dn);
    check_eq("stall_push_b_cycle", push_it[cmd_base+1], 32'd7);
    check_eq("stall_push_op_cycle", push_it[cmd_base+2], 32'd8);
    stall_on_first = 1'b0;

    // Start held high: one command per IDLE visit, next starts right after done.
    d0 = done_it.size();
    cmd_base = push_q.size();
    it = 0;
    i_op_a = 8'h12;
    i_op_b = 8'h34;
    i_op_code = 6'h25;
    i_start = 1'b1;
    guard = 0;
    while ((push_q.size() - cmd_base < 4) && (guard < 100)) begin
      tick();
      guard++;
    end
    i_start = 1'b0;
    while ((done_it.size() - d0 < 2) && (guard < 200)) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check_eq("held_done_count", done_it.size() - d0, 32'd2);
    check_eq("held_push_count", push_q.size() - cmd_base, 32'd6);
    if ((done_it.size() - d0 >= 2) && (push_q.size() - cmd_base >= 6)) begin
      check_eq("held_restart_cycle", push_it[cmd_base+3], done_it[d0] + 1);
      check_eq("held_second_a", push_q[cmd_base+3], 32'h12);
      check_eq("held_result", res_at_done[$], alu_ref(8'h12, 8'h34, 6'h25));
    end

    // Reset while stalled in SEND_B abandons the command.
    stall_on_first = 1'b1;
    stall_len = 3;
    issue(8'h77, 8'h66, 6'h24);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("midrst_wr", {31'd0, o_wr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall_rem = 0;
    stall_on_first = 1'b0;
    resp_cnt = -1;
    rx_q.delete();
    d0 = push_q.size();
    repeat (6) tick();
    check_eq("midrst_no_push", push_q.size() - d0, 32'd0);
    check_eq("midrst_idle", {31'd0, o_busy}, 32'd0);
    check_eq("midrst_result", o_result, 32'd0);
    run_cmd(8'hFF, 8'h01, 6'h22, dn);

`ifdef ALU_CMD_TIMEOUT_EN
    // No reply: timeout pulse 16 cycles after entering the wait.
    resp_en = 1'b0;
    d0 = done_it.size();
    dn = to_it.size();
    issue(8'h01, 8'h02, 6'h20);
    guard = 0;
    while ((to_it.size() == dn) && (guard < 100)) begin
      tick();
      guard++;
    end
    check_eq("to_seen", to_it.size() - dn, 32'd1);
    if (to_it.size() > dn) check_eq("to_cycle", to_it[$], 32'd20);
    check_eq("to_idle", {31'd0, o_busy}, 32'd0);
    check_eq("to_no_done", done_it.size() - d0, 32'd0);
    check_eq("to_keeps_result", o_result, alu_ref(8'hFF, 8'h01, 6'h22));
    tick();
    check_eq("to_single_pulse", to_it.size() - dn, 32'd1);
    resp_en = 1'b1;
`else
    // No reply: the wait is unbounded; a late reply still completes it.
    resp_en = 1'b0;
    d0 = done_it.size();
    issue(8'h01, 8'h02, 6'h20);
    repeat (40) tick();
    check_eq("wait_still_busy", {31'd0, o_busy}, 32'd1);
    check_eq("wait_no_timeout", to_it.size(), 32'd0);
    rx_q.push_back(8'h03);
    guard = 0;
    while ((done_it.size() == d0) && (guard < 20)) begin
      tick();
      guard++;
    end
    check_eq("late_reply_done", done_it.size() - d0, 32'd1);
    tick();
    check_eq("late_reply_result", o_result, 32'h03);
    resp_en = 1'b1;
`endif

    // Randomized commands with random TX back-pressure, reply delay and strays.
    for (int k = 0; k < 25; k++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = (k % 2 == 1) ? ops[$urandom_range(7)] : 6'($urandom);
      full_pct   = $urandom_range(50);
      resp_delay = $urandom_range(6);
      run_cmd(ra, rb, rop, dn);
      if ($urandom_range(3) == 0) begin
        d0 = done_it.size();
        rx_q.push_back(8'($urandom));
        repeat (3) tick();
        check_eq("rand_stray_drained", rx_q.size(), 32'd0);
        check_eq("rand_stray_result", o_result, alu_ref(ra, rb, rop));
        check_eq("rand_stray_no_done", done_it.size() - d0, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
